lock_sequencer: RTL and testbench

Central controller for the keypad smart lock. It consumes debounced, edge-detected key pulses and sequences code entry, comparison, unlock hold, failed-attempt counting and lockout. It sits between the per-key button edge detectors and the lock actuator output. It replaces the one-shot, sticky-state behaviour of the bare lock with a re-arming, timed lock.

---
 rtl/lock_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_lock_sequencer.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_sequencer.sv
// lock_sequencer
//   Keypad smart-lock controller. Sequences code entry, comparison, timed
//   unlock hold, consecutive-failure counting and timed lockout.
//
//   Optional feature: define CODE_PROG_EN to allow reprogramming the code
//   from the UNLOCKED state (PROG state, shadow register, code_updated pulse).
//   Without it the code is fixed at DEFAULT_CODE and prog_req is ignored.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   key_valid     one-cycle key pulse, digit on key_digit
//   key_digit     digit 0..9 (10..15 ignored)
//   key_clear     abort entry in progress
//   lock_now      force relock while unlocked
//   prog_req      request code reprogramming (CODE_PROG_EN only)
//   unlock        actuator drive
//   locked_out    high during lockout
//   entering      high while digits are being collected
//   digit_cnt     digits accepted in current entry (saturates at 7)
//   fail_cnt      consecutive failed entries
//   fail_pulse    one-cycle pulse per failed entry
//   code_updated  one-cycle pulse when a new code is stored
module lock_sequencer #(
    parameter int unsigned           CODE_LEN       = 4,
    parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE   = 16'h2479,
    parameter int unsigned           MAX_TRIES      = 3,
    parameter int unsigned           UNLOCK_CYCLES  = 500,
    parameter int unsigned           LOCKOUT_CYCLES = 1000,
    parameter int unsigned           ENTRY_TIMEOUT  = 2000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           key_valid,
    input  logic [3:0]                     key_digit,
    input  logic                           key_clear,
    input  logic                           lock_now,
    input  logic                           prog_req,
    output logic                           unlock,
    output logic                           locked_out,
    output logic                           entering,
    output logic [2:0]                     digit_cnt,
    output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt,
    output logic                           fail_pulse,
    output logic                           code_updated
);

    localparam int unsigned FW   = $clog2(MAX_TRIES + 1);
    localparam int unsigned TM1  = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TMAX = (TM1 > ENTRY_TIMEOUT) ? TM1 : ENTRY_TIMEOUT;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] UNLOCK_LAST  = TW'(UNLOCK_CYCLES);
    localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] ENTRY_LAST   = TW'(ENTRY_TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_SAT    = TW'(TMAX);
    localparam logic [FW-1:0] TRIES        = FW'(MAX_TRIES);
    localparam logic [3:0]    LAST_IDX     = 4'(CODE_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        UNLOCKED,
        FAIL,
        LOCKOUT
`ifdef CODE_PROG_EN
        , PROG
`endif
    } state_t;

    state_t                 state, state_next;
    logic [3:0]             cnt, cnt_next;
    logic                   mismatch, mismatch_next;
    logic [FW-1:0]          fail_next;
    logic [TW-1:0]          timer, timer_next;
    logic                   unlock_next;
    logic                   digit_ok;
    logic                   digit_take;
    logic [3:0]             exp_digit;
    logic [4*CODE_LEN-1:0]  code;

`ifdef CODE_PROG_EN
    logic [4*CODE_LEN-1:0]  code_q, shadow_q, shadow_next;
    logic                   commit;
    assign code = code_q;
`else
    logic                   prog_unused;
    assign code         = DEFAULT_CODE;
    assign code_updated = 1'b0;
    assign prog_unused  = prog_req;
`endif

    assign digit_ok = key_valid && (key_digit <= 4'd9);

    // Code nibble selected by the current digit index; digit 0 is the MSB nibble.
    always_comb begin
        exp_digit = '0;
        for (int unsigned i = 0; i < CODE_LEN; i++) begin
            if (cnt == 4'(i)) exp_digit = code[4*(CODE_LEN-1-i) +: 4];
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        mismatch_next = mismatch;
        fail_next     = fail_cnt;
        digit_take    = 1'b0;
`ifdef CODE_PROG_EN
        shadow_next   = shadow_q;
        commit        = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (digit_ok) begin
                    cnt_next      = 4'd1;
                    mismatch_next = (key_digit != exp_digit);
                    state_next    = (CODE_LEN == 1) ? CHECK : ENTRY;
                end
            end
            ENTRY: begin
                if (key_clear) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (digit_ok) begin
                    digit_take    = 1'b1;
                    mismatch_next = mismatch | (key_digit != exp_digit);
                    cnt_next      = cnt + 4'd1;
                    if (cnt == LAST_IDX) state_next = CHECK;
                end else if (timer == ENTRY_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            CHECK: begin
                cnt_next      = '0;
                mismatch_next = 1'b0;
                if (!mismatch) begin
                    state_next = UNLOCKED;
                    fail_next  = '0;
                end else begin
                    state_next = FAIL;
                    fail_next  = (fail_cnt == TRIES) ? TRIES : fail_cnt + 1'b1;
                end
            end
            FAIL: begin
                state_next = (fail_cnt == TRIES) ? LOCKOUT : IDLE;
            end
            UNLOCKED: begin
                if (lock_now) begin
                    state_next = IDLE;
`ifdef CODE_PROG_EN
                end else if (prog_req) begin
                    state_next = PROG;
                    cnt_next   = '0;
`endif
                end else if (timer == UNLOCK_LAST) begin
                    state_next = IDLE;
                end
            end
            LOCKOUT: begin
                if (timer == LOCKOUT_LAST) begin
                    state_next = IDLE;
                    fail_next  = '0;
                end
            end
`ifdef CODE_PROG_EN
            PROG: begin
                if (key_clear) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (digit_ok) begin
                    digit_take = 1'b1;
                    for (int unsigned i = 0; i < CODE_LEN; i++) begin
                        if (cnt == 4'(i)) shadow_next[4*(CODE_LEN-1-i) +: 4] = key_digit;
                    end
                    cnt_next = cnt + 4'd1;
                    if (cnt == LAST_IDX) begin
                        commit     = 1'b1;
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end else if (timer == ENTRY_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
`endif
            default: state_next = IDLE;
        endcase

        if (state_next != state || digit_take) timer_next = '0;
        else if (timer != TIMER_SAT)           timer_next = timer + 1'b1;
        else                                   timer_next = timer;

        // unlock is registered one cycle behind UNLOCKED entry, so UNLOCKED
        // spans UNLOCK_CYCLES+1 cycles; any exit drops unlock at the exit edge.
        unlock_next = (state == UNLOCKED) && (state_next == UNLOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            mismatch <= 1'b0;
            fail_cnt <= '0;
            timer    <= '0;
            unlock   <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            mismatch <= mismatch_next;
            fail_cnt <= fail_next;
            timer    <= timer_next;
            unlock   <= unlock_next;
        end
    end

`ifdef CODE_PROG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            code_q       <= DEFAULT_CODE;
            shadow_q     <= DEFAULT_CODE;
            code_updated <= 1'b0;
        end else begin
            shadow_q     <= shadow_next;
            code_updated <= commit;
            if (commit) code_q <= shadow_next;
        end
    end
`endif

    assign locked_out = (state == LOCKOUT);
    assign fail_pulse = (state == FAIL);
    assign digit_cnt  = (cnt > 4'd7) ? 3'd7 : cnt[2:0];
`ifdef CODE_PROG_EN
    assign entering   = (state == ENTRY) || (state == PROG);
`else
    assign entering   = (state == ENTRY);
`endif

endmodule

// File: tb/tb_lock_sequencer.sv
// tb_lock_sequencer
//   Self-checking bench for lock_sequencer with default parameters.
//   Expected behaviour comes from a scenario-level model: the stored code as
//   a digit array, a consecutive-failure count, and cycle counts for the
//   unlock/lockout/timeout windows.
module tb_lock_sequencer;

    localparam int CODE_LEN       = 4;
    localparam int MAX_TRIES      = 3;
    localparam int UNLOCK_CYCLES  = 500;
    localparam int LOCKOUT_CYCLES = 1000;
    localparam int ENTRY_TIMEOUT  = 2000;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       key_clear;
    logic       lock_now;
    logic       prog_req;
    logic       unlock;
    logic       locked_out;
    logic       entering;
    logic [2:0] digit_cnt;
    logic [1:0] fail_cnt;
    logic       fail_pulse;
    logic       code_updated;

    int checks   = 0;
    int failures = 0;
    int pulse_cnt = 0;
    int upd_cnt   = 0;
    int model_fail = 0;
    int code_model[CODE_LEN] = '{2, 4, 7, 9};

    lock_sequencer #(
        .CODE_LEN       (CODE_LEN),
        .DEFAULT_CODE   (16'h2479),
        .MAX_TRIES      (MAX_TRIES),
        .UNLOCK_CYCLES  (UNLOCK_CYCLES),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
        .ENTRY_TIMEOUT  (ENTRY_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_digit    (key_digit),
        .key_clear    (key_clear),
        .lock_now     (lock_now),
        .prog_req     (prog_req),
        .unlock       (unlock),
        .locked_out   (locked_out),
        .entering     (entering),
        .digit_cnt    (digit_cnt),
        .fail_cnt     (fail_cnt),
        .fail_pulse   (fail_pulse),
        .code_updated (code_updated)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (fail_pulse)   pulse_cnt++;
        if (code_updated) upd_cnt++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clear_inputs();
        key_valid = 1'b0; key_digit = '0; key_clear = 1'b0;
        lock_now  = 1'b0; prog_req  = 1'b0;
    endtask

    task automatic press(input int d);
        key_valid = 1'b1;
        key_digit = 4'(d);
        tick();
        key_valid = 1'b0;
    endtask

    // Random idle gap with ignored events (invalid digits, lock_now outside UNLOCKED).
    task automatic gap_noise();
        int n = $urandom_range(0, 4);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                key_valid = 1'b1;
                key_digit = 4'($urandom_range(10, 15));
            end
            lock_now = 1'($urandom_range(0, 1));
            tick();
            key_valid = 1'b0;
            lock_now  = 1'b0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        model_fail = 0;
        code_model = '{2, 4, 7, 9};
        tick();
    endtask

    // Enter a full sequence from IDLE and check the outcome two edges after the last digit.
    task automatic run_entry(input int seq[CODE_LEN], input string tag, input bit fixed_gap,
                             output bit ok, output bit lock_exp);
        bit match = 1'b1;
        int p0;
        for (int i = 0; i < CODE_LEN; i++) if (seq[i] != code_model[i]) match = 1'b0;
        p0 = pulse_cnt;
        for (int i = 0; i < CODE_LEN; i++) begin
            press(seq[i]);
            if (i < CODE_LEN - 1) begin
                checks++;
                if ({entering, digit_cnt} !== {1'b1, 3'(i + 1)}) begin
                    failures++;
                    $display("FAIL %s digit_progress: got entering=%b digit_cnt=%0d want 1/%0d",
                             tag, entering, digit_cnt, i + 1);
                end
                if (fixed_gap) idle(9); else gap_noise();
            end
        end
        tick();
        checks++;
        if (unlock !== 1'b0) begin
            failures++;
            $display("FAIL %s early_unlock: got %b want 0", tag, unlock);
        end
        tick();
        if (match) model_fail = 0;
        else if (model_fail < MAX_TRIES) model_fail++;
        lock_exp = !match && (model_fail == MAX_TRIES);
        checks++;
        if (unlock !== match) begin
            failures++;
            $display("FAIL %s unlock: got %b want %b", tag, unlock, match);
        end
        checks++;
        if (pulse_cnt - p0 != (match ? 0 : 1)) begin
            failures++;
            $display("FAIL %s fail_pulses: got %0d want %0d", tag, pulse_cnt - p0, match ? 0 : 1);
        end
        checks++;
        if (fail_cnt !== 2'(model_fail)) begin
            failures++;
            $display("FAIL %s fail_cnt: got %0d want %0d", tag, fail_cnt, model_fail);
        end
        checks++;
        if ({locked_out, entering} !== {lock_exp, 1'b0}) begin
            failures++;
            $display("FAIL %s state_flags: got locked_out=%b entering=%b want %b/0",
                     tag, locked_out, entering, lock_exp);
        end
        ok = match;
    endtask

    // Called on the first unlocked cycle; follows the hold to auto-relock.
    task automatic check_unlock_hold(input string tag);
        bit held = 1'b1;
        for (int i = 0; i < UNLOCK_CYCLES - 1; i++) begin
            key_valid = 1'($urandom_range(0, 1));
            key_digit = 4'($urandom_range(0, 15));
            key_clear = 1'($urandom_range(0, 1));
            tick();
            if (unlock !== 1'b1) held = 1'b0;
        end
        clear_inputs();
        checks++;
        if (!held) begin
            failures++;
            $display("FAIL %s unlock_hold: got early drop want %0d cycles high", tag, UNLOCK_CYCLES);
        end
        tick();
        checks++;
        if ({unlock, entering} !== 2'b00) begin
            failures++;
            $display("FAIL %s auto_relock: got unlock=%b entering=%b want 0/0", tag, unlock, entering);
        end
    endtask

    task automatic lock_now_exit(input string tag, input int wait_n);
        bit held = 1'b1;
        for (int i = 0; i < wait_n; i++) begin
            tick();
            if (unlock !== 1'b1) held = 1'b0;
        end
        lock_now = 1'b1;
        tick();
        lock_now = 1'b0;
        checks++;
        if (!held || unlock !== 1'b0 || entering !== 1'b0) begin
            failures++;
            $display("FAIL %s lock_now: got held=%b unlock=%b want held=1 unlock=0", tag, held, unlock);
        end
    endtask

    // Called on the first lockout cycle; all inputs are thrown at it meanwhile.
    task automatic check_lockout(input string tag);
        bit held = 1'b1;
        for (int i = 0; i < LOCKOUT_CYCLES - 1; i++) begin
            key_valid = 1'($urandom_range(0, 1));
            key_digit = 4'($urandom_range(0, 15));
            key_clear = 1'($urandom_range(0, 3) == 0);
            lock_now  = 1'($urandom_range(0, 1));
            prog_req  = 1'($urandom_range(0, 1));
            tick();
            if ({locked_out, entering, unlock} !== 3'b100) held = 1'b0;
        end
        clear_inputs();
        checks++;
        if (!held) begin
            failures++;
            $display("FAIL %s lockout_hold: got early exit or activity want %0d cycles", tag, LOCKOUT_CYCLES);
        end
        tick();
        model_fail = 0;
        checks++;
        if ({locked_out, fail_cnt} !== 3'b000) begin
            failures++;
            $display("FAIL %s lockout_exit: got locked_out=%b fail_cnt=%0d want 0/0", tag, locked_out, fail_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        idle(2);
        checks++;
        if ({unlock, locked_out, entering, digit_cnt, fail_cnt, fail_pulse, code_updated} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got nonzero outputs want all 0");
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_unlock();
        bit ok, lk;
        run_entry('{2, 4, 7, 9}, "tp1", 1'b1, ok, lk);
        check_unlock_hold("tp1");
    endtask

    task automatic test_fail();
        bit ok, lk;
        run_entry('{2, 1, 4, 7}, "tp2", 1'b1, ok, lk);
    endtask

    task automatic test_lockout();
        bit ok, lk;
        do_reset();
        run_entry('{1, 1, 1, 1}, "tp3a", 1'b0, ok, lk);
        run_entry('{2, 4, 7, 8}, "tp3b", 1'b0, ok, lk);
        run_entry('{9, 4, 7, 9}, "tp3c", 1'b0, ok, lk);
        if (lk) check_lockout("tp3");
        run_entry('{2, 4, 7, 9}, "tp3d", 1'b0, ok, lk);
        lock_now_exit("tp3d", 3);
    endtask

    task automatic test_clear();
        bit ok, lk;
        int p0 = pulse_cnt;
        press(2);
        press(4);
        key_valid = 1'b1; key_digit = 4'd7; key_clear = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if ({entering, digit_cnt} !== 4'b0000) begin
            failures++;
            $display("FAIL clear_abort: got entering=%b digit_cnt=%0d want 0/0", entering, digit_cnt);
        end
        idle(3);
        checks++;
        if (pulse_cnt != p0 || fail_cnt !== 2'(model_fail)) begin
            failures++;
            $display("FAIL clear_no_fail: got pulses=%0d fail_cnt=%0d want 0/%0d", pulse_cnt - p0, fail_cnt, model_fail);
        end
        run_entry('{2, 4, 7, 9}, "tp4", 1'b0, ok, lk);
        lock_now_exit("tp4", 2);
    endtask

    task automatic test_lock_now_reset();
        bit ok, lk;
        run_entry('{2, 4, 7, 9}, "tp5a", 1'b0, ok, lk);
        lock_now_exit("tp5a", 9);
        run_entry('{2, 4, 7, 9}, "tp5b", 1'b0, ok, lk);
        idle(5);
        reset = 1'b1;
        tick();
        checks++;
        if ({unlock, locked_out, entering, digit_cnt, fail_cnt, fail_pulse, code_updated} !== '0) begin
            failures++;
            $display("FAIL reset_mid_unlock: got unlock=%b want all outputs 0", unlock);
        end
        reset = 1'b0;
        model_fail = 0;
        code_model = '{2, 4, 7, 9};
        tick();
    endtask

    task automatic test_timeout();
        bit ok, lk;
        int p0;
        run_entry('{5, 5, 5, 5}, "tp5c", 1'b0, ok, lk);
        p0 = pulse_cnt;
        press(2);
        press(4);
        idle(ENTRY_TIMEOUT - 1);
        checks++;
        if ({entering, digit_cnt} !== {1'b1, 3'd2}) begin
            failures++;
            $display("FAIL timeout_early: got entering=%b digit_cnt=%0d want 1/2", entering, digit_cnt);
        end
        tick();
        checks++;
        if ({entering, digit_cnt} !== 4'b0000 || fail_cnt !== 2'(model_fail) || pulse_cnt != p0) begin
            failures++;
            $display("FAIL timeout_exit: got entering=%b digit_cnt=%0d fail_cnt=%0d want 0/0/%0d",
                     entering, digit_cnt, fail_cnt, model_fail);
        end
    endtask

    task automatic test_prog();
        bit ok, lk;
        int u0 = upd_cnt;
        run_entry(code_model, "tp6a", 1'b0, ok, lk);
        idle(3);
        prog_req = 1'b1;
        tick();
        prog_req = 1'b0;
`ifdef CODE_PROG_EN
        checks++;
        if ({unlock, entering} !== 2'b01) begin
            failures++;
            $display("FAIL prog_enter: got unlock=%b entering=%b want 0/1", unlock, entering);
        end
        press(1); press(3); press(5); press(8);
        checks++;
        if ({code_updated, entering} !== 2'b10) begin
            failures++;
            $display("FAIL prog_commit: got code_updated=%b entering=%b want 1/0", code_updated, entering);
        end
        code_model = '{1, 3, 5, 8};
        idle(2);
        checks++;
        if (upd_cnt - u0 != 1) begin
            failures++;
            $display("FAIL prog_pulse_count: got %0d want 1", upd_cnt - u0);
        end
        run_entry('{2, 4, 7, 9}, "tp6old", 1'b0, ok, lk);
        run_entry('{1, 3, 5, 8}, "tp6new", 1'b0, ok, lk);
        idle(2);
        prog_req = 1'b1;
        tick();
        prog_req = 1'b0;
        press(9);
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        run_entry('{1, 3, 5, 8}, "tp6keep", 1'b0, ok, lk);
        lock_now_exit("tp6keep", 1);
`else
        checks++;
        if ({unlock, entering} !== 2'b10) begin
            failures++;
            $display("FAIL prog_ignored: got unlock=%b entering=%b want 1/0", unlock, entering);
        end
        lock_now_exit("tp6a", 1);
        run_entry('{2, 4, 7, 9}, "tp6b", 1'b0, ok, lk);
        lock_now_exit("tp6b", 1);
        checks++;
        if (upd_cnt != u0) begin
            failures++;
            $display("FAIL code_updated_tied: got %0d pulses want 0", upd_cnt - u0);
        end
`endif
    endtask

    task automatic test_random();
        bit ok, lk;
        int seq[CODE_LEN];
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 9) < 4) seq = code_model;
            else for (int i = 0; i < CODE_LEN; i++) seq[i] = $urandom_range(0, 9);
            run_entry(seq, "rand", 1'b0, ok, lk);
            if (ok)      lock_now_exit("rand", $urandom_range(0, 20));
            else if (lk) check_lockout("rand");
            idle($urandom_range(0, 3));
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_unlock();
        test_fail();
        test_lockout();
        test_clear();
        test_lock_now_reset();
        test_timeout();
        test_prog();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
